// File: rtl/event_word_serializer.sv
// Pops event words from the show-ahead event FIFO and streams them out LSB-first as
// OWIDTH-bit valid/ready beats, chaining words back-to-back without an idle beat.
module event_word_serializer #(
  parameter int unsigned DWIDTH = 136,
  parameter int unsigned OWIDTH = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_rdata,
  output logic              fifo_rd_en,
  output logic [OWIDTH-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int unsigned NBEATS = (DWIDTH + OWIDTH - 1) / OWIDTH;
  localparam int unsigned SWIDTH = NBEATS * OWIDTH;
  localparam int unsigned BCW    = $clog2(NBEATS);

  localparam logic [0:0]     IDLE      = 1'b0;
  localparam logic [0:0]     SEND      = 1'b1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(NBEATS - 1);

  logic [0:0]        state_q, state_d;
  logic [SWIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              accept;
  logic              load;

  assign busy      = (state_q == SEND);
  assign out_valid = busy;
  assign out_data  = busy ? shift_q[OWIDTH-1:0] : '0;
  assign out_last  = busy && (beat_cnt_q == LAST_BEAT);
  assign word_cnt  = word_cnt_q;

  assign accept = out_valid && out_ready;
  // rst_n gates the pop so a FIFO with data is never drained while held in reset.
  assign load       = rst_n && en && !fifo_empty && (!busy || (accept && out_last));
  assign fifo_rd_en = load;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    beat_cnt_d = beat_cnt_q;
    word_cnt_d = word_cnt_q;

    if (accept && out_last) begin
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end

    if (load) begin
      // Zero-extend so any padding bits of the final beat read as 0.
      shift_d                = '0;
      shift_d[DWIDTH-1:0]    = fifo_rdata;
      beat_cnt_d             = '0;
      state_d                = SEND;
    end else if (accept) begin
      if (out_last) begin
        state_d = IDLE;
      end else begin
        shift_d    = shift_q >> OWIDTH;
        beat_cnt_d = beat_cnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      beat_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      beat_cnt_q <= beat_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_event_word_serializer.sv
// Bench for event_word_serializer: a queue-based beat model checked every cycle on the
// default 8-bit instance, plus hand-checked reset/padding vectors on a 32-bit instance.
module tb_event_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- main instance (OWIDTH = 8) ----------------
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic         fifo_empty = 1'b1;
  logic [135:0] fifo_rdata = '0;
  logic         fifo_rd_en;
  logic [7:0]   out_data;
  logic         out_valid, out_last, busy;
  logic         out_ready = 1'b1;
  logic [15:0]  word_cnt;

  event_word_serializer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .word_cnt(word_cnt)
  );

  // ---------------- padding instance (OWIDTH = 32) ----------------
  logic         rst2_n = 1'b0;
  logic         fifo2_empty = 1'b1;
  logic [135:0] fifo2_rdata = '0;
  logic         rd2_en, valid2, last2, busy2;
  logic [31:0]  data2;
  logic [15:0]  cnt2;

  event_word_serializer #(.DWIDTH(136), .OWIDTH(32), .CNT_W(16)) dut2 (
    .clk(clk), .rst_n(rst2_n), .en(1'b1), .fifo_empty(fifo2_empty),
    .fifo_rdata(fifo2_rdata), .fifo_rd_en(rd2_en), .out_data(data2), .out_valid(valid2),
    .out_last(last2), .out_ready(1'b1), .busy(busy2), .word_cnt(cnt2)
  );

  // ---------------- FIFO model: mem/wr_ptr from stimulus, rd_ptr from pops ----------------
  logic [135:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_req = 0;

  always @(posedge clk) begin
    rd_ptr = pop_req;
    fifo_empty <= (wr_ptr == rd_ptr);
    fifo_rdata <= (wr_ptr == rd_ptr) ? 136'd0 : mem[rd_ptr % 16];
  end

  // ---------------- beat model and per-cycle compare ----------------
  logic [7:0]  exp_data [$];
  bit          exp_last [$];
  logic [15:0] m_cnt = '0;
  logic [7:0]  acc_log [256];
  int          acc_n = 0;
  int          rd_pulses = 0;
  int          rd_with_last = 0;
  bit          prev_hold = 0;
  logic [7:0]  hold_data;
  logic        hold_last;

  always @(negedge clk) begin : monitor
    bit has, exp_rd;
    if (!rst_n) begin
      check("rst_valid", out_valid, 0);
      check("rst_rd_en", fifo_rd_en, 0);
      check("rst_busy", busy, 0);
      check("rst_word_cnt", word_cnt, 0);
      exp_data.delete();
      exp_last.delete();
      m_cnt = '0;
      prev_hold = 0;
    end else begin
      has = (exp_data.size() != 0);
      check("valid", out_valid, has);
      check("busy", busy, has);
      check("word_cnt", word_cnt, m_cnt);
      if (has) begin
        check("data", out_data, exp_data[0]);
        check("last", out_last, exp_last[0]);
      end
      if (prev_hold) begin
        check("hold_data", out_data, hold_data);
        check("hold_last", out_last, hold_last);
      end
      // A word is fetched when enabled, data is waiting, and nothing would still be pending.
      exp_rd = en && !fifo_empty && (!has || (exp_last[0] && out_ready));
      check("rd_en", fifo_rd_en, exp_rd);

      if (out_valid && out_ready && has) begin
        acc_log[acc_n % 256] = exp_data[0];
        acc_n++;
        if (exp_last[0]) m_cnt = m_cnt + 16'd1;
        exp_data.delete(0);
        exp_last.delete(0);
      end
      if (fifo_rd_en) begin
        rd_pulses++;
        if (out_valid && out_ready && out_last) rd_with_last++;
        for (int k = 0; k < 17; k++) begin
          exp_data.push_back(fifo_rdata[8*k +: 8]);
          exp_last.push_back(k == 16);
        end
        pop_req++;
      end
      prev_hold = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [135:0] mk(input logic [7:0] base);
    logic [135:0] w = '0;
    for (int i = 0; i < 17; i++) w[8*i +: 8] = base + 8'(i);
    return w;
  endfunction

  task automatic push(input logic [135:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int want, input int base);
    int guard = 0;
    while (!((acc_n - base) >= want && !out_valid) && guard < 200) begin
      step();
      guard++;
    end
    check("drain_timeout", guard < 200, 1);
  endtask

  task automatic check_log(input string nm, input int base, input logic [7:0] first,
                           input int n);
    for (int i = 0; i < n; i++) check(nm, acc_log[(base + i) % 256], first + 8'(i));
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    int base, rbase, lbase, vcyc, nb;
    logic [31:0] beats [8];
    logic [7:0]  lasts;

    // Reset with data waiting and en=1: nothing may pop until release.
    push(mk(8'h00));
    repeat (3) step();
    @(negedge clk);
    check("reset_rd_en", fifo_rd_en, 0);
    check("reset_valid", out_valid, 0);
    step();
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    @(negedge clk);
    check("first_pop", fifo_rd_en, 1);

    // Single word, ready held high.
    base = 0;
    drain(17, base);
    check("single_beats", acc_n - base, 17);
    check_log("single_order", base, 8'h00, 17);
    check("single_cnt", word_cnt, 1);
    check("single_pulses", rd_pulses, 1);
    check("single_busy", busy, 0);

    // Backpressure: ready alternates 0,1,0,1...
    base = acc_n;
    out_ready = 1'b0;
    push(mk(8'h00));
    for (int c = 0; c < 200 && !((acc_n - base) >= 17 && !out_valid); c++) begin
      step();
      out_ready = ~out_ready;
    end
    check("bp_beats", acc_n - base, 17);
    check_log("bp_order", base, 8'h00, 17);
    check("bp_cnt", word_cnt, 2);
    out_ready = 1'b1;
    step();

    // Back-to-back A then B with no gap.
    base  = acc_n;
    rbase = rd_with_last;
    vcyc  = 0;
    push(mk(8'h20));
    push(mk(8'h40));
    for (int c = 0; c < 200 && !((acc_n - base) >= 34 && !out_valid); c++) begin
      @(negedge clk);
      if (out_valid) vcyc++;
      step();
    end
    check("b2b_beats", acc_n - base, 34);
    check("b2b_valid_cycles", vcyc, 34);
    check_log("b2b_a", base, 8'h20, 17);
    check_log("b2b_b", base + 17, 8'h40, 17);
    check("b2b_rd_at_last", rd_with_last - rbase, 1);
    check("b2b_cnt", word_cnt, 4);

    // Enable gating: drop en mid-word with B already waiting.
    base  = acc_n;
    lbase = rd_pulses;
    push(mk(8'h60));
    push(mk(8'h70));
    for (int c = 0; c < 100 && (acc_n - base) < 5; c++) step();
    en = 1'b0;
    repeat (30) step();
    check("gate_a_beats", acc_n - base, 17);
    check("gate_pulses", rd_pulses - lbase, 1);
    check("gate_idle", busy, 0);
    check("gate_cnt", word_cnt, 5);
    check_log("gate_a", base, 8'h60, 17);
    en = 1'b1;
    @(negedge clk);
    check("gate_resume_pop", fifo_rd_en, 1);
    drain(34, base);
    check_log("gate_b", base + 17, 8'h70, 17);
    check("gate_cnt2", word_cnt, 6);

    // Reset mid-word on the 32-bit instance, then a padded word.
    step();
    fifo2_empty = 1'b0;
    fifo2_rdata = mk(8'h00);
    @(negedge clk);
    check("p_pop", rd2_en, 1);
    step();
    fifo2_empty = 1'b1;
    @(negedge clk);
    check("p_beat0", data2, 32'h03020100);
    step();
    @(negedge clk);
    check("p_beat1", data2, 32'h07060504);
    step();
    @(negedge clk);
    check("p_beat2", data2, 32'h0B0A0908);
    #1 rst2_n = 1'b0;
    #1;
    check("p_rst_valid", valid2, 0);
    check("p_rst_data", data2, 0);
    check("p_rst_last", last2, 0);
    check("p_rst_busy", busy2, 0);
    step();
    rst2_n = 1'b1;
    fifo2_empty = 1'b0;
    fifo2_rdata = mk(8'h80);
    nb = 0;
    lasts = '0;
    for (int c = 0; c < 12; c++) begin
      bit popped;
      @(negedge clk);
      popped = rd2_en;
      if (valid2 && nb < 8) begin
        beats[nb] = data2;
        lasts[nb] = last2;
        nb++;
      end
      step();
      if (popped) fifo2_empty = 1'b1;
    end
    check("p_nbeats", nb, 5);
    check("p_w0", beats[0], 32'h83828180);
    check("p_w3", beats[3], 32'h8F8E8D8C);
    check("p_w4", beats[4], 32'h00000090);
    check("p_pad_zero", beats[4][31:8], 0);
    check("p_lasts", lasts, 8'b0001_0000);
    check("p_cnt", cnt2, 1);
    check("p_idle", valid2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/event_word_serializer.md
Name: event_word_serializer

Overview:
- Drains 136-bit event words from the OpenDVS event sync FIFO and emits them as a narrow valid/ready beat stream toward the chip output interface (pad/SPI driver).
- Sits directly downstream of the FIFO. Pops one word at a time and shifts it out LSB-first in OWIDTH-bit beats.
- Supports back-to-back words with no idle beat between them.

Parameters:
- DWIDTH, 136, width of FIFO word; must equal the FIFO DWIDTH.
- OWIDTH, 8, output beat width; 1 <= OWIDTH < DWIDTH.
- NBEATS, derived, equal to ceil(DWIDTH/OWIDTH) (17 at defaults); must be >= 2.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  fetch enable; gates new FIFO pops only.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DWIDTH  FIFO head word; show-ahead, valid whenever fifo_empty=0.
- fifo_rd_en  out  1  pop strobe to FIFO.
- out_data  out  OWIDTH  current beat.
- out_valid  out  1  beat valid.
- out_last  out  1  final beat of the current word.
- out_ready  in  1  sink accepts beat.
- busy  out  1  a word is held (state SEND).
- word_cnt  out  CNT_W  words fully delivered; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-low; clock clk) forces the following, with immediate effect and no clock needed:
  - state IDLE;
  - shift register = 0, beat_cnt = 0, word_cnt = 0;
  - out_valid = 0, out_last = 0, out_data = 0, busy = 0.
  - fifo_rd_en = 0 while rst_n = 0.
- States: IDLE, SEND.
- Load condition (combinational): load = en && !fifo_empty && (state==IDLE || (state==SEND && accept && out_last)).
  - accept = out_valid && out_ready.
- fifo_rd_en = load, combinational.
  - Never asserted when fifo_empty = 1.
  - Asserted for exactly one cycle per word.
- On the clk edge where load = 1:
  - shift register <= fifo_rdata, zero-extended to NBEATS*OWIDTH bits;
  - beat_cnt <= 0; state <= SEND.
- Latency: out_valid rises the cycle after the load edge, i.e. 1 cycle from the first fifo_rd_en.
- SEND outputs:
  - out_valid = 1;
  - out_data = shift[OWIDTH-1:0];
  - out_last = (beat_cnt == NBEATS-1).
- SEND on accept with out_last = 0: shift register shifts right by OWIDTH (zero fill), beat_cnt increments.
- SEND on accept with out_last = 1:
  - word_cnt increments;
  - if load, the next word loads (no bubble);
  - otherwise state <= IDLE and out_valid falls the next cycle.
- Backpressure: while out_valid && !out_ready, out_data and out_last are held stable. out_valid never drops without acceptance.
- Padding: when DWIDTH is not a multiple of OWIDTH, bits of the final beat above DWIDTH are 0.
- en = 0:
  - an in-flight word completes normally;
  - no new pop occurs, including at the last-beat boundary.
  - en has no effect on beats already loaded.
- Reset mid-word: the partially sent word is discarded (it was already popped). After release, the next word starts at beat 0.
- busy = (state == SEND).
- beat_cnt width is $clog2(NBEATS). beat_cnt never exceeds NBEATS-1.

Test Plan:
- Reset check: hold rst_n = 0 with fifo_empty = 0 and en = 1.
  - Expect fifo_rd_en = 0, out_valid = 0, busy = 0, word_cnt = 0.
  - After release, fifo_rd_en pulses on the first cycle.
- Single word: byte i of the word = i (bytes 0x00..0x10), out_ready = 1, FIFO then empty.
  - One fifo_rd_en pulse.
  - 17 consecutive beats 0x00..0x10; out_last only on 0x10.
  - Then out_valid = 0, busy = 0, word_cnt = 1.
- Backpressure: same word, out_ready pattern 0,1,0,1...
  - Every beat is held stable until accepted.
  - 17 beats in order, no duplicate or dropped beat; out_last on 0x10.
- Back-to-back: FIFO holds words A and B, out_ready = 1.
  - 34 consecutive valid beats with no gap.
  - Second fifo_rd_en coincides with acceptance of A's last beat.
  - word_cnt = 2.
- Enable gating: clear en at beat 5 of word A while the FIFO is non-empty.
  - A completes all 17 beats; no further fifo_rd_en while en = 0.
  - Setting en = 1 pops B on the next cycle.
- Reset mid-word plus padding (OWIDTH = 32): assert rst_n = 0 at beat 2.
  - Outputs clear immediately.
  - After release, the next word yields 5 beats; beat 4 bits [31:8] = 0.
